// File: rtl/alu_button_sequencer_pkg.sv
// Shared opcode constants and sequencer state encoding for the button-driven ALU front end.
package alu_pkg;

  localparam int unsigned NB_OP_DEF = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  // Encoding is visible on the debug LEDs, so values are fixed.
  typedef enum logic [2:0] {
    ST_WAIT_A   = 3'd0,
    ST_WAIT_B   = 3'd1,
    ST_WAIT_OPR = 3'd2,
    ST_COMPUTE  = 3'd3,
    ST_SHOW     = 3'd4
  } state_e;

endpackage

// File: rtl/alu_button_sequencer_if.sv
// Board-side bundle: switches and raw buttons in, result LEDs and status out.
interface alu_button_sequencer_if #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OUT  = 16
);
  logic [NB_DATA-1:0] i_switches;
  logic               i_btn_op1;
  logic               i_btn_op2;
  logic               i_btn_opr;
  logic [NB_OUT-1:0]  o_leds;
  logic               o_valid;
  logic               o_zero;
  logic               o_ovf;
  logic               o_err;
  logic [2:0]         o_state;

  modport master (
    output i_switches, i_btn_op1, i_btn_op2, i_btn_opr,
    input  o_leds, o_valid, o_zero, o_ovf, o_err, o_state
  );

  modport slave (
    input  i_switches, i_btn_op1, i_btn_op2, i_btn_opr,
    output o_leds, o_valid, o_zero, o_ovf, o_err, o_state
  );
endinterface

// File: rtl/alu_button_sequencer_btn_conditioner.sv
// Raw push-button to single-cycle press pulse: 2-FF synchroniser, stability debounce, rising edge.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d, db_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter measures how long the synced level has disagreed with the accepted level;
  // any return to agreement restarts it, so glitches never accumulate.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign pulse_o = db_q & ~db_prev_q;
endmodule

// File: rtl/alu_button_sequencer.sv
// Button-sequenced ALU front end: latches operands/opcode from switches, shows registered result.
module alu_button_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA         = 8,
  parameter int unsigned NB_OP           = NB_OP_DEF,
  parameter int unsigned NB_OUT          = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned ORDERED         = 1
) (
  input  logic                  clk,
  input  logic                  i_reset,
  alu_button_sequencer_if.slave bus
);
  logic p_op1, p_op2, p_opr;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_op1 (
    .clk_i(clk), .rst_ni(i_reset), .btn_i(bus.i_btn_op1), .pulse_o(p_op1));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_op2 (
    .clk_i(clk), .rst_ni(i_reset), .btn_i(bus.i_btn_op2), .pulse_o(p_op2));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_opr (
    .clk_i(clk), .rst_ni(i_reset), .btn_i(bus.i_btn_opr), .pulse_o(p_opr));

  state_e             state_q, state_d;
  logic               ld_a, ld_b, ld_op;
  logic [NB_DATA-1:0] a_q, b_q;
  logic [NB_OP-1:0]   op_q;
  logic               a_seen_q, b_seen_q, op_seen_q;
  logic [NB_OUT-1:0]  leds_q;
  logic               zero_q, ovf_q, err_q;

  always_comb begin
    state_d = state_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_op   = 1'b0;
    if (ORDERED != 0) begin
      case (state_q)
        ST_WAIT_A:   if (p_op1) begin ld_a = 1'b1; state_d = ST_WAIT_B; end
        ST_WAIT_B:   if (p_op2) begin ld_b = 1'b1; state_d = ST_WAIT_OPR; end
        ST_WAIT_OPR: if (p_opr) begin ld_op = 1'b1; state_d = ST_COMPUTE; end
        ST_COMPUTE:  state_d = ST_SHOW;
        ST_SHOW: begin
          if (p_op1) begin
            ld_a = 1'b1; state_d = ST_WAIT_B;
          end else if (p_op2) begin
            ld_b = 1'b1; state_d = ST_WAIT_OPR;
          end else if (p_opr) begin
            ld_op = 1'b1; state_d = ST_COMPUTE;
          end
        end
        default: state_d = ST_WAIT_A;
      endcase
    end else begin
      // Free entry: SHOW lags the last first-time load by one cycle, lining up with the result register.
      ld_a    = p_op1;
      ld_b    = p_op2;
      ld_op   = p_opr;
      state_d = (a_seen_q & b_seen_q & op_seen_q) ? ST_SHOW : ST_WAIT_A;
    end
  end

  logic [NB_DATA:0]   wide;
  logic [NB_DATA-1:0] lg;
  logic [NB_OUT-1:0]  res;
  logic               arith, unk, ovf;

  always_comb begin
    wide  = '0;
    lg    = '0;
    res   = '0;
    arith = 1'b0;
    unk   = 1'b0;
    ovf   = 1'b0;
    case (op_q)
      NB_OP'(OP_ADD): begin arith = 1'b1; wide = {a_q[NB_DATA-1], a_q} + {b_q[NB_DATA-1], b_q}; end
      NB_OP'(OP_SUB): begin arith = 1'b1; wide = {a_q[NB_DATA-1], a_q} - {b_q[NB_DATA-1], b_q}; end
      NB_OP'(OP_AND): lg = a_q & b_q;
      NB_OP'(OP_OR):  lg = a_q | b_q;
      NB_OP'(OP_XOR): lg = a_q ^ b_q;
      NB_OP'(OP_NOR): lg = ~(a_q | b_q);
      NB_OP'(OP_SRL): lg = b_q >> a_q[2:0];
      NB_OP'(OP_SRA): lg = $signed(b_q) >>> a_q[2:0];
      default:        unk = 1'b1;
    endcase
    if (arith) begin
      res = NB_OUT'($signed(wide));
      ovf = wide[NB_DATA] ^ wide[NB_DATA-1];
    end else if (!unk) begin
      res = NB_OUT'($signed(lg));
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state_q   <= ST_WAIT_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      a_seen_q  <= 1'b0;
      b_seen_q  <= 1'b0;
      op_seen_q <= 1'b0;
      leds_q    <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ld_a)  a_q  <= bus.i_switches;
      if (ld_b)  b_q  <= bus.i_switches;
      if (ld_op) op_q <= bus.i_switches[NB_OP-1:0];
      a_seen_q  <= a_seen_q | ld_a;
      b_seen_q  <= b_seen_q | ld_b;
      op_seen_q <= op_seen_q | ld_op;
      leds_q    <= res;
      zero_q    <= ~unk & (res == '0);
      ovf_q     <= ovf;
      // The cleared opcode register is not a user choice, so it never raises an error.
      err_q     <= op_seen_q & unk;
    end
  end

  assign bus.o_leds  = leds_q;
  assign bus.o_valid = (state_q == ST_SHOW);
  assign bus.o_zero  = zero_q & bus.o_valid;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_err   = err_q;
  assign bus.o_state = state_q;
endmodule

// File: tb/tb_alu_button_sequencer.sv
// Drives an ordered and a free-entry instance with identical board stimulus and checks both against a reference model.
module tb_alu_button_sequencer;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  bit   chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_button_sequencer_if #(.NB_DATA(8), .NB_OUT(16)) bus1 ();
  alu_button_sequencer_if #(.NB_DATA(8), .NB_OUT(16)) bus0 ();

  alu_button_sequencer #(.NB_DATA(8), .NB_OP(6), .NB_OUT(16), .DEBOUNCE_CYCLES(D), .ORDERED(1))
    dut1 (.clk(clk), .i_reset(rst_n), .bus(bus1));
  alu_button_sequencer #(.NB_DATA(8), .NB_OP(6), .NB_OUT(16), .DEBOUNCE_CYCLES(D), .ORDERED(0))
    dut0 (.clk(clk), .i_reset(rst_n), .bus(bus0));

  typedef struct packed {
    logic [15:0] leds;
    logic        ovf;
    logic        unk;
  } ref_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    int t;
    t = $signed(v);
    return 16'(t);
  endfunction

  function automatic ref_t ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    ref_t r;
    int   sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (op)
      6'b100000: begin s = sa + sb; r.leds = 16'(s); r.ovf = (s > 127) || (s < -128); end
      6'b100010: begin s = sa - sb; r.leds = 16'(s); r.ovf = (s > 127) || (s < -128); end
      6'b100100: r.leds = sext8(a & b);
      6'b100101: r.leds = sext8(a | b);
      6'b100110: r.leds = sext8(a ^ b);
      6'b100111: r.leds = sext8(~(a | b));
      6'b000010: begin s = int'(b) >> a[2:0]; r.leds = sext8(8'(s)); end
      6'b000011: begin s = sb >>> a[2:0]; r.leds = 16'(s); end
      default:   r.unk = 1'b1;
    endcase
    return r;
  endfunction

  // Reference model: a press is accepted once D consecutive synced samples agree
  logic [15:0] hist [3];
  logic        db_m [3];
  logic        pend_m [3];
  logic [7:0]  ma [2];
  logic [7:0]  mb [2];
  logic [5:0]  mop [2];
  logic        sa_m [2];
  logic        sb_m [2];
  logic        sop_m [2];
  logic [15:0] e_leds [2];
  logic        e_ovf [2];
  logic        e_err [2];
  logic        e_zraw [2];
  int          stage1;
  int          e_st0;

  always @(posedge clk) begin : model
    logic [15:0] h;
    logic        nd;
    logic [2:0]  raw;
    ref_t        r;
    raw = {bus1.i_btn_opr, bus1.i_btn_op2, bus1.i_btn_op1};
    if (!rst_n) begin
      for (int b = 0; b < 3; b++) begin
        hist[b] <= '0; db_m[b] <= 1'b0; pend_m[b] <= 1'b0;
      end
      for (int m = 0; m < 2; m++) begin
        ma[m] <= '0; mb[m] <= '0; mop[m] <= '0;
        sa_m[m] <= 1'b0; sb_m[m] <= 1'b0; sop_m[m] <= 1'b0;
        e_leds[m] <= '0; e_ovf[m] <= 1'b0; e_err[m] <= 1'b0; e_zraw[m] <= 1'b0;
      end
      stage1 <= 0;
      e_st0  <= 0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        h = {hist[b][14:0], raw[b]};
        hist[b] <= h;
        if (h[D+1:2] == {D{1'b1}})   nd = 1'b1;
        else if (h[D+1:2] == '0)     nd = 1'b0;
        else                         nd = db_m[b];
        db_m[b]   <= nd;
        pend_m[b] <= nd & ~db_m[b];
      end
      for (int m = 0; m < 2; m++) begin
        r = ref_alu(ma[m], mb[m], mop[m]);
        e_leds[m] <= r.leds;
        e_ovf[m]  <= r.ovf;
        e_err[m]  <= sop_m[m] & r.unk;
        e_zraw[m] <= ~r.unk & (r.leds == 16'h0000);
      end
      e_st0 <= (sa_m[0] & sb_m[0] & sop_m[0]) ? 4 : 0;
      if (pend_m[0]) begin ma[0] <= bus1.i_switches; sa_m[0] <= 1'b1; end
      if (pend_m[1]) begin mb[0] <= bus1.i_switches; sb_m[0] <= 1'b1; end
      if (pend_m[2]) begin mop[0] <= bus1.i_switches[5:0]; sop_m[0] <= 1'b1; end
      case (stage1)
        0: if (pend_m[0]) begin ma[1] <= bus1.i_switches; stage1 <= 1; end
        1: if (pend_m[1]) begin mb[1] <= bus1.i_switches; stage1 <= 2; end
        2: if (pend_m[2]) begin mop[1] <= bus1.i_switches[5:0]; sop_m[1] <= 1'b1; stage1 <= 3; end
        3: stage1 <= 4;
        default: begin
          if (pend_m[0]) begin ma[1] <= bus1.i_switches; stage1 <= 1; end
          else if (pend_m[1]) begin mb[1] <= bus1.i_switches; stage1 <= 2; end
          else if (pend_m[2]) begin mop[1] <= bus1.i_switches[5:0]; sop_m[1] <= 1'b1; stage1 <= 3; end
        end
      endcase
    end
  end

  task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("ord.o_leds",  bus1.o_leds, e_leds[1]);
      cmp("ord.o_valid", 16'(bus1.o_valid), 16'(stage1 == 4));
      cmp("ord.o_zero",  16'(bus1.o_zero), 16'(e_zraw[1] && stage1 == 4));
      cmp("ord.o_ovf",   16'(bus1.o_ovf), 16'(e_ovf[1]));
      cmp("ord.o_err",   16'(bus1.o_err), 16'(e_err[1]));
      cmp("ord.o_state", 16'(bus1.o_state), 16'(stage1));
      cmp("free.o_leds",  bus0.o_leds, e_leds[0]);
      cmp("free.o_valid", 16'(bus0.o_valid), 16'(e_st0 == 4));
      cmp("free.o_zero",  16'(bus0.o_zero), 16'(e_zraw[0] && e_st0 == 4));
      cmp("free.o_ovf",   16'(bus0.o_ovf), 16'(e_ovf[0]));
      cmp("free.o_err",   16'(bus0.o_err), 16'(e_err[0]));
      cmp("free.o_state", 16'(bus0.o_state), 16'(e_st0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // btn bit0 = op1, bit1 = op2, bit2 = opr
  task automatic drive(input logic [2:0] btn, input logic [7:0] sw);
    bus1.i_btn_op1 = btn[0]; bus1.i_btn_op2 = btn[1]; bus1.i_btn_opr = btn[2];
    bus0.i_btn_op1 = btn[0]; bus0.i_btn_op2 = btn[1]; bus0.i_btn_opr = btn[2];
    bus1.i_switches = sw;
    bus0.i_switches = sw;
  endtask

  task automatic press(input logic [2:0] btn, input logic [7:0] sw);
    drive(btn, sw);
    cyc(10);
    drive(3'b000, sw);
    cyc(10);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(3'b000, 8'h00);
    cyc(3);
    chk_en = 1'b1;
    cmp("lit reset leds", bus1.o_leds, 16'h0000);
    cmp("lit reset state", 16'(bus1.o_state), 16'd0);
    cmp("lit reset valid", 16'(bus1.o_valid), 16'd0);
    rst_n = 1'b1;
    cyc(2);

    press(3'b100, 8'h20);
    cmp("lit opr in WAIT_A ignored", 16'(bus1.o_state), 16'd0);

    press(3'b001, 8'h05);
    press(3'b010, 8'h03);
    press(3'b100, 8'h20);
    cmp("lit 5+3 leds", bus1.o_leds, 16'h0008);
    cmp("lit 5+3 valid", 16'(bus1.o_valid), 16'd1);
    cmp("lit 5+3 state", 16'(bus1.o_state), 16'd4);
    cmp("lit 5+3 zero", 16'(bus1.o_zero), 16'd0);
    cmp("lit 5+3 ovf", 16'(bus1.o_ovf), 16'd0);

    press(3'b001, 8'h7F);
    press(3'b010, 8'h01);
    press(3'b100, 8'h20);
    cmp("lit 7F+1 leds", bus1.o_leds, 16'h0080);
    cmp("lit 7F+1 ovf", 16'(bus1.o_ovf), 16'd1);

    press(3'b001, 8'h80);
    press(3'b010, 8'h01);
    press(3'b100, 8'h22);
    cmp("lit 80-1 leds", bus1.o_leds, 16'hFF7F);
    cmp("lit 80-1 ovf", 16'(bus1.o_ovf), 16'd1);

    press(3'b001, 8'h05);
    press(3'b010, 8'h03);
    press(3'b100, 8'h22);
    cmp("lit 5-3 leds", bus1.o_leds, 16'h0002);
    press(3'b001, 8'h05);
    cmp("lit reload valid", 16'(bus1.o_valid), 16'd0);
    cmp("lit reload state", 16'(bus1.o_state), 16'd1);

    press(3'b010, 8'hF0);
    press(3'b100, 8'h3F);
    cmp("lit bad op err", 16'(bus1.o_err), 16'd1);
    cmp("lit bad op leds", bus1.o_leds, 16'h0000);
    press(3'b001, 8'h0F);
    press(3'b010, 8'hF0);
    press(3'b100, 8'h26);
    cmp("lit xor leds", bus1.o_leds, 16'hFFFF);
    cmp("lit xor err", 16'(bus1.o_err), 16'd0);

    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 8'h55); cyc(1);
      drive(3'b000, 8'h55); cyc(1);
    end
    drive(3'b001, 8'h55); cyc(3);
    drive(3'b000, 8'h55); cyc(8);
    cmp("lit bounce state", 16'(bus1.o_state), 16'd4);
    cmp("lit bounce leds", bus1.o_leds, 16'hFFFF);

    drive(3'b001, 8'h11); cyc(10);
    drive(3'b000, 8'h11); cyc(1);
    drive(3'b001, 8'h22); cyc(9);
    drive(3'b000, 8'h22); cyc(10);
    cmp("lit steady press state", 16'(bus1.o_state), 16'd1);
    cmp("lit free A once leds", bus0.o_leds, 16'hFFE1);

    press(3'b010, 8'h01);
    press(3'b100, 8'h20);
    cmp("lit 11+1 leds", bus1.o_leds, 16'h0012);
    rst_n = 1'b0;
    cyc(1);
    cmp("lit rst leds", bus1.o_leds, 16'h0000);
    cmp("lit rst valid", 16'(bus1.o_valid), 16'd0);
    cmp("lit rst state", 16'(bus1.o_state), 16'd0);
    cmp("lit rst ovf", 16'(bus1.o_ovf), 16'd0);
    cmp("lit rst free valid", 16'(bus0.o_valid), 16'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    drive(3'b001, 8'h09); cyc(3);
    rst_n = 1'b0; cyc(2);
    drive(3'b000, 8'h09);
    rst_n = 1'b1; cyc(12);
    cmp("lit mid-debounce state", 16'(bus1.o_state), 16'd0);

    press(3'b011, 8'h07);
    press(3'b100, 8'h20);
    cmp("lit free simul leds", bus0.o_leds, 16'h000E);
    cmp("lit free simul valid", 16'(bus0.o_valid), 16'd1);
    cmp("lit free simul state", 16'(bus0.o_state), 16'd4);
    cmp("lit ord simul state", 16'(bus1.o_state), 16'd1);

    chk_en = 1'b0;
    cyc(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
